// File: rtl/alu_sequencer.sv
// Single-issue ALU controller: accepts one logic/shift operation, returns the result and
// maintains the zero/carry/sign status. A right shift by N takes N one-bit steps.
module alu_sequencer #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [2:0]       status,
    output logic             busy
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_LDSR = 4'd6;
    localparam logic [3:0] OP_XSR  = 4'd7;
    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;   // also the working register during SHIFT
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [2:0]       status_q, status_d;
    logic [CNT_W-1:0] req_cnt, sat_cnt;
    logic [WIDTH-1:0] logic_res, shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            status_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = (req_op == OP_SHR) ? SHIFT : EXEC;
            EXEC:    state_d = RESP;
            SHIFT:   if (cnt_q <= CNT_W'(1)) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        err_d       = err_q;
        status_d    = status_q;
        req_cnt     = req_b[CNT_W-1:0];
        sat_cnt     = (req_cnt > SAT_CNT) ? SAT_CNT : req_cnt;
        shifted     = {1'b0, a_q[WIDTH-1:1]};
        logic_res   = '0;
        unique case (state_q)
            IDLE: if (req_valid) begin
                op_d  = req_op;
                a_d   = req_a;
                b_d   = req_b;
                cnt_d = sat_cnt;
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                result_d    = '0;
                case (op_q)
                    OP_NOT, OP_AND, OP_OR, OP_XOR: begin
                        case (op_q)
                            OP_NOT:  logic_res = ~a_q;
                            OP_AND:  logic_res = a_q & b_q;
                            OP_OR:   logic_res = a_q | b_q;
                            default: logic_res = a_q ^ b_q;
                        endcase
                        result_d = logic_res;
                        status_d = {logic_res[WIDTH-1], 1'b0, ~|logic_res};
                    end
                    OP_NOP:  ;
                    OP_LDSR: status_d = a_q[2:0];
                    OP_XSR:  status_d = status_q ^ a_q[2:0];
                    default: err_d = 1'b1;
                endcase
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    // zero-count shift still costs one cycle and passes A through
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b0;
                    result_d    = a_q;
                    status_d    = {a_q[WIDTH-1], 1'b0, ~|a_q};
                end else begin
                    a_d   = shifted;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b0;
                        result_d    = shifted;
                        status_d    = {1'b0, a_q[0], ~|shifted};
                    end
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        rsp_valid  = rsp_valid_q;
        rsp_result = result_q;
        rsp_err    = err_q;
        status     = status_q;
    end

endmodule
